// File: rtl/uart_host_if.sv
// Memory-mapped host port for the uart core: TX FIFO feeding ld_tx_data/tx_data and an RX holding register unloaded via uld_rx_data.
// Optional interrupt output and CTRL[3:2] enables are built only when UART_IRQ_EN is defined.
module uart_host_if #(
    parameter int TX_DEPTH = 16,
    parameter int AW       = 2
) (
    input  logic          txclk,
    input  logic          reset,
    input  logic          sel,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          ready,
    output logic          ld_tx_data,
    output logic [7:0]    tx_data,
    output logic          tx_enable,
    input  logic          tx_empty,
    output logic          uld_rx_data,
    input  logic [7:0]    rx_data,
    output logic          rx_enable,
    input  logic          rx_empty
`ifdef UART_IRQ_EN
    ,
    output logic          irq
`endif
);

    localparam int IW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int PW = IW + 1;

    localparam logic [AW-1:0] A_DATA   = AW'(0);
    localparam logic [AW-1:0] A_STATUS = AW'(1);
    localparam logic [AW-1:0] A_CTRL   = AW'(2);

    typedef enum logic [1:0] {T_IDLE, T_LOAD, T_WAIT} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_UNLD, R_CAP, R_WAIT} rx_state_t;

    tx_state_t tx_state, tx_state_nxt;
    rx_state_t rx_state, rx_state_nxt;

    logic          ctrl_tx_en;
    logic          ctrl_rx_en;
    logic          ctrl_tx_ie;
    logic          ctrl_rx_ie;

    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          tx_pop;
    logic          push_ok;
    logic          tx_start;
    logic          tx_drop;

    logic [7:0]    rx_hold;
    logic          rx_valid;
    logic          rx_start;

    logic          wr_data;
    logic          rd_data;
    logic          wr_status;
    logic          wr_ctrl;
    logic [31:0]   rd_word_p0;

    logic          unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    // Bus decode (stage p0: combinational, same cycle as sel)
    assign wr_data   = sel &&  we && (addr == A_DATA);
    assign rd_data   = sel && !we && (addr == A_DATA);
    assign wr_status = sel &&  we && (addr == A_STATUS);
    assign wr_ctrl   = sel &&  we && (addr == A_CTRL);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                        (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

    // The head byte is copied into tx_data before the pop, so a push into a
    // full FIFO may safely reuse that slot on the pop cycle.
    assign tx_pop   = (tx_state == T_LOAD);
    assign push_ok  = wr_data && (!fifo_full || tx_pop);
    assign tx_start = ctrl_tx_en && !fifo_empty && tx_empty;
    assign rx_start = ctrl_rx_en && !rx_empty && !rx_valid;

    assign tx_enable = ctrl_tx_en;
    assign rx_enable = ctrl_rx_en;

    always_ff @(posedge txclk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr[IW-1:0]] <= wdata[7:0];
        end
    end

    always_ff @(posedge txclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge txclk) begin
        if (reset) begin
            tx_drop <= 1'b0;
        end else if (wr_data && fifo_full && !tx_pop) begin
            tx_drop <= 1'b1;
        end else if (wr_status && wdata[4]) begin
            tx_drop <= 1'b0;
        end
    end

    always_ff @(posedge txclk) begin
        if (reset) begin
            ctrl_tx_en <= 1'b0;
            ctrl_rx_en <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_tx_en <= wdata[0];
            ctrl_rx_en <= wdata[1];
        end
    end

`ifdef UART_IRQ_EN
    always_ff @(posedge txclk) begin
        if (reset) begin
            ctrl_tx_ie <= 1'b0;
            ctrl_rx_ie <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_tx_ie <= wdata[2];
            ctrl_rx_ie <= wdata[3];
        end
    end

    always_ff @(posedge txclk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= (ctrl_rx_ie && rx_valid) || (ctrl_tx_ie && fifo_empty);
        end
    end
`else
    assign ctrl_tx_ie = 1'b0;
    assign ctrl_rx_ie = 1'b0;
`endif

    always_ff @(posedge txclk) begin
        if (reset) begin
            tx_state <= T_IDLE;
        end else begin
            tx_state <= tx_state_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            T_IDLE: if (tx_start) tx_state_nxt = T_LOAD;
            T_LOAD: tx_state_nxt = T_WAIT;
            T_WAIT: if (!tx_empty) tx_state_nxt = T_IDLE;
            default: tx_state_nxt = T_IDLE;
        endcase
    end

    always_comb begin
        ld_tx_data = (tx_state == T_LOAD);
    end

    always_ff @(posedge txclk) begin
        if (reset) begin
            tx_data <= 8'h00;
        end else if ((tx_state == T_IDLE) && tx_start) begin
            tx_data <= fifo_mem[rd_ptr[IW-1:0]];
        end
    end

    always_ff @(posedge txclk) begin
        if (reset) begin
            rx_state <= R_IDLE;
        end else begin
            rx_state <= rx_state_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            R_IDLE: if (rx_start) rx_state_nxt = R_UNLD;
            R_UNLD: rx_state_nxt = R_CAP;
            R_CAP:  rx_state_nxt = R_WAIT;
            R_WAIT: if (rx_empty) rx_state_nxt = R_IDLE;
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        uld_rx_data = (rx_state == R_UNLD);
    end

    // rx_valid is always clear in R_CAP, so a DATA read can never race a capture.
    always_ff @(posedge txclk) begin
        if (reset) begin
            rx_hold  <= 8'h00;
            rx_valid <= 1'b0;
        end else if (rx_state == R_CAP) begin
            rx_hold  <= rx_data;
            rx_valid <= 1'b1;
        end else if (rd_data && rx_valid) begin
            rx_valid <= 1'b0;
        end
    end

    always_comb begin
        rd_word_p0 = 32'h0;
        case (addr)
            A_DATA:   rd_word_p0 = {24'h0, (rx_valid ? rx_hold : 8'h00)};
            A_STATUS: rd_word_p0 = {27'h0, tx_drop, rx_valid, fifo_full, fifo_empty, tx_empty};
            A_CTRL:   rd_word_p0 = {28'h0, ctrl_rx_ie, ctrl_tx_ie, ctrl_rx_en, ctrl_tx_en};
            default:  rd_word_p0 = 32'h0;
        endcase
    end

    // Bus response (stage p1: registered, one cycle after sel)
    always_ff @(posedge txclk) begin
        if (reset) begin
            ready <= 1'b0;
            rdata <= 32'h0;
        end else begin
            ready <= sel;
            rdata <= (sel && !we) ? rd_word_p0 : 32'h0;
        end
    end

endmodule
